// File: rtl/axi4lite_seq_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_seq_checker_if
// Brief    : AXI4-Lite bus bundle used by the sequential write/readback checker.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4lite_seq_checker_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/axi4lite_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_seq_checker
// Brief    : AXI4-Lite master self-test: writes NUM_WORDS words, reads them
//            back and counts data/response errors.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_seq_checker #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS          = 4,
    parameter logic [63:0] BASE_ADDR          = 64'h0,
    parameter logic [63:0] START_DATA         = 64'h1,
    parameter int unsigned DATA_MODE          = 0,
    parameter int unsigned STOP_ON_ERR        = 0,
    localparam int unsigned c_CW              = $clog2(2*NUM_WORDS+1)
) (
    input  wire                         ACLK,
    input  wire                         ARESETN,
    input  wire                         start,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [c_CW-1:0]             err_count,
    output logic [7:0]                  first_err_idx,
    axi4lite_seq_checker_if.master      m_axi
);

    localparam int unsigned             c_AW       = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned             c_DW       = C_M_AXI_DATA_WIDTH;
    localparam int unsigned             c_ADDR_LSB = $clog2(c_DW/8);
    localparam logic [c_AW-1:0]         c_BASE     = BASE_ADDR[c_AW-1:0];
    localparam logic [7:0]              c_LAST     = 8'(NUM_WORDS-1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_idx, w_idx_nxt;
    logic               r_awvalid, w_awvalid_nxt;
    logic               r_wvalid, w_wvalid_nxt;
    logic               r_arvalid, w_arvalid_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_pass, w_pass_nxt;
    logic [c_CW-1:0]    r_err_count, w_err_count_nxt;
    logic [7:0]         r_first_err_idx, w_first_err_idx_nxt;
    logic               w_err_event;
    logic               w_aw_left, w_w_left;
    logic [c_DW-1:0]    w_exp;
    logic [c_AW-1:0]    w_addr;

    // Expected/write data for the current word; arithmetic wraps at c_DW bits.
    generate
        if (DATA_MODE == 0) begin : g_mode_inc
            localparam logic [c_DW-1:0] c_START = START_DATA[c_DW-1:0];
            assign w_exp = c_START + c_DW'(r_idx);
        end else begin : g_mode_walk
            localparam int unsigned c_SHW = $clog2(c_DW);
            assign w_exp = {{(c_DW-1){1'b0}}, 1'b1} << r_idx[c_SHW-1:0];
        end
    endgenerate

    assign w_addr = c_BASE + (c_AW'(r_idx) << c_ADDR_LSB);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_awvalid       <= 1'b0;
            r_wvalid        <= 1'b0;
            r_arvalid       <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_idx           <= w_idx_nxt;
            r_awvalid       <= w_awvalid_nxt;
            r_wvalid        <= w_wvalid_nxt;
            r_arvalid       <= w_arvalid_nxt;
            r_busy          <= w_busy_nxt;
            r_done          <= w_done_nxt;
            r_pass          <= w_pass_nxt;
            r_err_count     <= w_err_count_nxt;
            r_first_err_idx <= w_first_err_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_idx_nxt           = r_idx;
        w_awvalid_nxt       = r_awvalid;
        w_wvalid_nxt        = r_wvalid;
        w_arvalid_nxt       = r_arvalid;
        w_busy_nxt          = r_busy;
        w_done_nxt          = 1'b0;
        w_pass_nxt          = r_pass;
        w_err_count_nxt     = r_err_count;
        w_first_err_idx_nxt = r_first_err_idx;
        w_err_event         = 1'b0;
        w_aw_left           = r_awvalid & ~m_axi.awready;
        w_w_left            = r_wvalid & ~m_axi.wready;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_err_count_nxt     = '0;
                    w_first_err_idx_nxt = '0;
                    w_pass_nxt          = 1'b0;
                    w_idx_nxt           = '0;
                    w_busy_nxt          = 1'b1;
                    w_awvalid_nxt       = 1'b1;
                    w_wvalid_nxt        = 1'b1;
                    w_state_nxt         = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                // AW and W retire independently; leave once neither is pending.
                w_awvalid_nxt = w_aw_left;
                w_wvalid_nxt  = w_w_left;
                if (!w_aw_left && !w_w_left) begin
                    w_state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (m_axi.bvalid) begin
                    w_err_event = (m_axi.bresp != 2'b00);
                    if (w_err_event && (STOP_ON_ERR != 0)) begin
                        w_state_nxt = S_FIN;
                    end else if (r_idx == c_LAST) begin
                        w_idx_nxt     = '0;
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = S_RD_ADDR;
                    end else begin
                        w_idx_nxt     = r_idx + 8'd1;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = S_WR_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                if (m_axi.arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_state_nxt   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (m_axi.rvalid) begin
                    w_err_event = (m_axi.rdata != w_exp) || (m_axi.rresp != 2'b00);
                    if ((w_err_event && (STOP_ON_ERR != 0)) || (r_idx == c_LAST)) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_idx_nxt     = r_idx + 8'd1;
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = S_RD_ADDR;
                    end
                end
            end
            S_FIN: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_pass_nxt  = (r_err_count == '0);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_err_event) begin
            if (r_err_count != '1) begin
                w_err_count_nxt = r_err_count + c_CW'(1);
            end
            if (r_err_count == '0) begin
                w_first_err_idx_nxt = r_idx;
            end
        end
    end

    assign m_axi.awaddr  = w_addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = w_exp;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = (r_state == S_WR_RESP);
    assign m_axi.araddr  = w_addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = (r_state == S_RD_DATA);

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4lite_seq_checker
// Brief    : Directed bench: three checker configurations, each beside a small
//            RAM slave with injectable delays, bad data and bad responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_seq_checker;

    logic clk;
    logic rstn;
    logic start [3];
    int   aw_wait [3];
    int   corrupt_idx [3];
    int   bresp_err_idx [3];
    wire  done_v [3];
    int   checks;
    int   passes;
    int   fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults; 1: STOP_ON_ERR; 2: walking one over 40 words.
    generate
        for (genvar g = 0; g < 3; g++) begin : g_inst
            localparam int unsigned NW = (g == 2) ? 40 : 4;
            localparam int unsigned DM = (g == 2) ? 1 : 0;
            localparam int unsigned SE = (g == 1) ? 1 : 0;
            localparam int unsigned CW = $clog2(2*NW+1);

            axi4lite_seq_checker_if #(.ADDR_W(32), .DATA_W(32)) bus ();

            logic          busy, done, pass;
            logic [CW-1:0] err_count;
            logic [7:0]    first_err_idx;

            axi4lite_seq_checker #(
                .NUM_WORDS  (NW),
                .DATA_MODE  (DM),
                .STOP_ON_ERR(SE)
            ) dut (
                .ACLK         (clk),
                .ARESETN      (rstn),
                .start        (start[g]),
                .busy         (busy),
                .done         (done),
                .pass         (pass),
                .err_count    (err_count),
                .first_err_idx(first_err_idx),
                .m_axi        (bus)
            );

            assign done_v[g] = done;

            logic [31:0] mem [0:63];
            int          aw_cnt, aw_run, aw_run_last, w_run, w_run_last;
            int          aw_total, r_total;
            logic        aw_got, w_got, prev_pending, addr_bad;
            logic [31:0] aw_addr_q, w_data_q, prev_addr;
            logic        aw_hs, w_hs, have_a, have_w;
            logic [31:0] cur_a, cur_d;

            assign bus.awready = bus.awvalid && (aw_cnt >= aw_wait[g]);
            assign bus.wready  = 1'b1;
            assign bus.arready = 1'b1;
            assign aw_hs  = bus.awvalid && bus.awready;
            assign w_hs   = bus.wvalid && bus.wready;
            assign have_a = aw_got || aw_hs;
            assign have_w = w_got || w_hs;
            assign cur_a  = aw_got ? aw_addr_q : bus.awaddr;
            assign cur_d  = w_got ? w_data_q : bus.wdata;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    aw_cnt       <= 0;
                    aw_run       <= 0;
                    w_run        <= 0;
                    aw_got       <= 1'b0;
                    w_got        <= 1'b0;
                    prev_pending <= 1'b0;
                    addr_bad     <= 1'b0;
                    bus.bvalid   <= 1'b0;
                    bus.bresp    <= 2'b00;
                    bus.rvalid   <= 1'b0;
                    bus.rresp    <= 2'b00;
                    bus.rdata    <= '0;
                end else begin
                    aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
                    if (bus.awvalid) begin
                        aw_run <= aw_hs ? 0 : aw_run + 1;
                        if (aw_hs) aw_run_last <= aw_run + 1;
                    end
                    if (bus.wvalid) begin
                        w_run <= w_hs ? 0 : w_run + 1;
                        if (w_hs) w_run_last <= w_run + 1;
                    end
                    if (aw_hs) aw_total <= aw_total + 1;
                    if (prev_pending && (!bus.awvalid || bus.awaddr != prev_addr)) addr_bad <= 1'b1;
                    prev_pending <= bus.awvalid && !bus.awready;
                    prev_addr    <= bus.awaddr;

                    if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
                    if (have_a && have_w) begin
                        mem[cur_a[7:2]] <= cur_d;
                        bus.bvalid      <= 1'b1;
                        bus.bresp       <= (int'(cur_a[7:2]) == bresp_err_idx[g]) ? 2'b10 : 2'b00;
                        aw_got          <= 1'b0;
                        w_got           <= 1'b0;
                    end else begin
                        if (aw_hs) begin
                            aw_got    <= 1'b1;
                            aw_addr_q <= bus.awaddr;
                        end
                        if (w_hs) begin
                            w_got    <= 1'b1;
                            w_data_q <= bus.wdata;
                        end
                    end

                    if (bus.rvalid && bus.rready) begin
                        bus.rvalid <= 1'b0;
                        r_total    <= r_total + 1;
                    end
                    if (bus.arvalid && bus.arready) begin
                        bus.rvalid <= 1'b1;
                        bus.rresp  <= 2'b00;
                        bus.rdata  <= (int'(bus.araddr[7:2]) == corrupt_idx[g]) ? 32'h0000DEAD
                                                                                : mem[bus.araddr[7:2]];
                    end
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulses start and counts cycles until done (bounded by budget).
    task automatic run(input int g, input int budget, output int cycles);
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
        cycles   = 1;
        while (done_v[g] !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        int aw0;
        int r0;
        int n;
        checks = 0;
        passes = 0;
        fails  = 0;
        rstn   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k]         = 1'b0;
            aw_wait[k]       = 0;
            corrupt_idx[k]   = -1;
            bresp_err_idx[k] = -1;
        end
        repeat (3) tick();

        chk("rst_valids", {g_inst[0].bus.awvalid, g_inst[0].bus.wvalid, g_inst[0].bus.arvalid,
                           g_inst[0].bus.bready, g_inst[0].bus.rready}, 5'b0);
        chk("rst_status", {g_inst[0].busy, g_inst[0].done, g_inst[0].pass}, 3'b0);
        chk("rst_err", {g_inst[0].err_count, g_inst[0].first_err_idx}, 12'h0);
        rstn = 1'b1;
        tick();

        // 1: clean run on defaults
        run(0, 200, cyc);
        chk("t1_latency", cyc, 18);
        chk("t1_pass", g_inst[0].pass, 1'b1);
        chk("t1_err", g_inst[0].err_count, 4'd0);
        chk("t1_busy", g_inst[0].busy, 1'b0);
        for (int k = 0; k < 4; k++) chk("t1_mem", g_inst[0].mem[k], 32'(k + 1));
        tick();
        chk("t1_done_pulse", g_inst[0].done, 1'b0);
        chk("t1_pass_held", g_inst[0].pass, 1'b1);

        // 2: word 2 read back as 0xDEAD
        corrupt_idx[0] = 2;
        r0 = g_inst[0].r_total;
        run(0, 200, cyc);
        chk("t2_pass", g_inst[0].pass, 1'b0);
        chk("t2_err", g_inst[0].err_count, 4'd1);
        chk("t2_first", g_inst[0].first_err_idx, 8'd2);
        chk("t2_reads", g_inst[0].r_total - r0, 4);
        corrupt_idx[0] = -1;
        tick();

        // 3: AWREADY held off so AWVALID spans 3 cycles
        aw_wait[0] = 2;
        run(0, 300, cyc);
        chk("t3_aw_len", g_inst[0].aw_run_last, 3);
        chk("t3_w_len", g_inst[0].w_run_last, 1);
        chk("t3_addr_stable", g_inst[0].addr_bad, 1'b0);
        chk("t3_pass", g_inst[0].pass, 1'b1);
        for (int k = 0; k < 4; k++) chk("t3_mem", g_inst[0].mem[k], 32'(k + 1));
        aw_wait[0] = 0;
        tick();

        // 4: SLVERR on word 0 with abort enabled
        bresp_err_idx[1] = 0;
        aw0 = g_inst[1].aw_total;
        run(1, 200, cyc);
        chk("t4_latency", cyc, 4);
        chk("t4_aw_count", g_inst[1].aw_total - aw0, 1);
        chk("t4_err", g_inst[1].err_count, 4'd1);
        chk("t4_first", g_inst[1].first_err_idx, 8'd0);
        chk("t4_pass", g_inst[1].pass, 1'b0);
        chk("t4_idle_bus", {g_inst[1].bus.awvalid, g_inst[1].bus.wvalid, g_inst[1].bus.arvalid}, 3'b0);
        tick();

        // 5: walking one, 40 words
        run(2, 1000, cyc);
        chk("t5_latency", cyc, 162);
        chk("t5_pass", g_inst[2].pass, 1'b1);
        chk("t5_err", g_inst[2].err_count, 7'd0);
        chk("t5_w0", g_inst[2].mem[0], 32'h00000001);
        chk("t5_w31", g_inst[2].mem[31], 32'h80000000);
        chk("t5_w33", g_inst[2].mem[33], 32'h00000002);
        tick();

        // 6: reset while waiting on read data, then a clean rerun
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n = 0;
        while (g_inst[0].bus.rready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("t6_reach_rd", g_inst[0].bus.rready, 1'b1);
        rstn = 1'b0;
        tick();
        chk("t6_valids", {g_inst[0].bus.awvalid, g_inst[0].bus.wvalid, g_inst[0].bus.arvalid,
                          g_inst[0].bus.bready, g_inst[0].bus.rready}, 5'b0);
        chk("t6_status", {g_inst[0].busy, g_inst[0].done, g_inst[0].pass}, 3'b0);
        rstn = 1'b1;
        tick();
        run(0, 200, cyc);
        chk("t6_latency", cyc, 18);
        chk("t6_pass", g_inst[0].pass, 1'b1);
        chk("t6_err", g_inst[0].err_count, 4'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
